// File: rtl/operand_feeder.sv
// -----------------------------------------------------------------------------
// operand_feeder
//
// Holds an N x N operand matrix in a register buffer and streams it into the
// row inputs of a systolic array with a diagonal skew. Row r is delayed by r
// cycles, so at feed step t row r carries A[r][t-r] when that column exists.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears state, buffer and outputs
//   wr_en      buffer write strobe (honoured in IDLE only)
//   wr_addr    buffer index, r*N + c selects A[r][c]
//   wr_data    operand value to store
//   start      begin a feed (sampled only in IDLE)
//   a_out      row operands, slice [r*DATA_W +: DATA_W] drives array row r
//   valid_out  per-row valid, bit r qualifies row r slice
//   busy       high while a feed step is being presented
//   done       one-cycle pulse after the final feed step
//
// Handshake: there is no back-pressure. A feed is a fixed 2N-1 cycle burst;
// valid_out[r] alone qualifies a_out row r in each cycle, and start is a
// request that is only accepted while the block is idle.
// -----------------------------------------------------------------------------
module operand_feeder #(
    parameter int DATA_W = 8,
    parameter int N      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(N*N)-1:0]     wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       start,
    output logic [N*DATA_W-1:0]        a_out,
    output logic [N-1:0]               valid_out,
    output logic                       busy,
    output logic                       done
);

    localparam int AW   = $clog2(N*N);
    localparam int T_W  = $clog2(2*N);
    localparam int LAST = 2*N - 2;

    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [T_W-1:0]        t_q, t_d;
    logic [DATA_W-1:0]     buf_q [N*N];
    logic [DATA_W-1:0]     buf_d [N*N];
    logic [N*DATA_W-1:0]   a_out_q, a_out_d;
    logic [N-1:0]          valid_out_q, valid_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Step whose outputs get registered on this edge, and whether one is.
    logic [T_W-1:0]        step_sel;
    logic                  load_step;
    logic [AW-1:0]         rd_idx;

    // -------------------------------------------------------------------------
    // Next-state / output computation
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        buf_d       = buf_q;
        a_out_d     = '0;
        valid_out_d = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        step_sel    = '0;
        load_step   = 1'b0;
        rd_idx      = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // An accepted start wins over a coincident write so the
                    // feed sees the buffer exactly as it was before this edge.
                    state_d   = FEED;
                    t_d       = '0;
                    load_step = 1'b1;
                    step_sel  = '0;
                end else if (wr_en && (int'(wr_addr) < N*N)) begin
                    buf_d[wr_addr] = wr_data;
                end
            end

            FEED: begin
                if (t_q == T_W'(LAST)) begin
                    state_d = IDLE;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d       = t_q + 1'b1;
                    load_step = 1'b1;
                    step_sel  = t_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                t_d     = '0;
            end
        endcase

        if (load_step) begin
            busy_d = 1'b1;
            // Row r shows column k = step - r when 0 <= k < N. Valid comes
            // from the skew window only, never from the operand value.
            for (int r = 0; r < N; r++) begin
                if ((int'(step_sel) >= r) && (int'(step_sel) - r < N)) begin
                    rd_idx = AW'(r*N + int'(step_sel) - r);
                    a_out_d[r*DATA_W +: DATA_W] = buf_q[rd_idx];
                    valid_out_d[r]              = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            buf_q       <= '{default: '0};
            a_out_q     <= '0;
            valid_out_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            buf_q       <= buf_d;
            a_out_q     <= a_out_d;
            valid_out_q <= valid_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_out     = a_out_q;
    assign valid_out = valid_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_operand_feeder.sv
// -----------------------------------------------------------------------------
// tb_operand_feeder
//
// Directed bench for operand_feeder. One instance at N=2 covers skew, zero
// operands, writes/start during a feed, start+write collision and reset
// mid-feed; a second instance at N=4 covers the longer skew and
// back-to-back feeds. Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_operand_feeder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- N=2 instance ----------------
    logic        wr_en2;
    logic [1:0]  wr_addr2;
    logic [7:0]  wr_data2;
    logic        start2;
    logic [15:0] a_out2;
    logic [1:0]  valid2;
    logic        busy2;
    logic        done2;

    operand_feeder #(.DATA_W(8), .N(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en2),
        .wr_addr   (wr_addr2),
        .wr_data   (wr_data2),
        .start     (start2),
        .a_out     (a_out2),
        .valid_out (valid2),
        .busy      (busy2),
        .done      (done2)
    );

    // ---------------- N=4 instance ----------------
    logic        wr_en4;
    logic [3:0]  wr_addr4;
    logic [7:0]  wr_data4;
    logic        start4;
    logic [31:0] a_out4;
    logic [3:0]  valid4;
    logic        busy4;
    logic        done4;

    operand_feeder #(.DATA_W(8), .N(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en4),
        .wr_addr   (wr_addr4),
        .wr_data   (wr_data4),
        .start     (start4),
        .a_out     (a_out4),
        .valid_out (valid4),
        .busy      (busy4),
        .done      (done4)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wr2(input logic [1:0] addr, input logic [7:0] data);
        wr_en2 = 1'b1; wr_addr2 = addr; wr_data2 = data;
        tick();
        wr_en2 = 1'b0;
    endtask

    task automatic wr4(input logic [3:0] addr, input logic [7:0] data);
        wr_en4 = 1'b1; wr_addr4 = addr; wr_data4 = data;
        tick();
        wr_en4 = 1'b0;
    endtask

    // Full N=2 feed. ea holds the three expected a_out words, step 0 lowest.
    // mid: write addr0=9 and pulse start during step 0.
    // col: write addr1=7 in the same cycle as start.
    task automatic feed2(input string tag, input logic [47:0] ea, input bit mid, input bit col);
        logic [5:0] ev;
        ev = 6'b10_11_01;
        start2 = 1'b1;
        if (col) begin
            wr_en2 = 1'b1; wr_addr2 = 2'd1; wr_data2 = 8'd7;
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            start2 = 1'b0;
            wr_en2 = 1'b0;
            chk($sformatf("%s_a_s%0d", tag, t), 64'(a_out2), 64'(ea[t*16 +: 16]));
            chk($sformatf("%s_v_s%0d", tag, t), 64'(valid2), 64'(ev[t*2 +: 2]));
            chk($sformatf("%s_busy_s%0d", tag, t), 64'(busy2), 64'd1);
            chk($sformatf("%s_done_s%0d", tag, t), 64'(done2), 64'd0);
            if (mid && t == 0) begin
                wr_en2 = 1'b1; wr_addr2 = 2'd0; wr_data2 = 8'd9;
                start2 = 1'b1;
            end
        end
        tick();
        chk($sformatf("%s_done", tag), 64'(done2), 64'd1);
        chk($sformatf("%s_done_busy", tag), 64'(busy2), 64'd0);
        chk($sformatf("%s_done_a", tag), 64'(a_out2), 64'd0);
        chk($sformatf("%s_done_v", tag), 64'(valid2), 64'd0);
        tick();
        chk($sformatf("%s_post_done", tag), 64'(done2), 64'd0);
        chk($sformatf("%s_post_busy", tag), 64'(busy2), 64'd0);
    endtask

    // Expected {valid, a_out} at step t for the N=4 matrix A[r][c] = 4r+c+1.
    function automatic logic [35:0] m4(input int t);
        logic [31:0] a;
        logic [3:0]  v;
        a = '0;
        v = '0;
        for (int r = 0; r < 4; r++) begin
            if (t - r >= 0 && t - r < 4) begin
                a[r*8 +: 8] = 8'(4*r + (t - r) + 1);
                v[r] = 1'b1;
            end
        end
        return {v, a};
    endfunction

    task automatic chk4_step(input string tag, input int t);
        logic [35:0] e;
        e = m4(t);
        chk($sformatf("%s_a_s%0d", tag, t), 64'(a_out4), 64'(e[31:0]));
        chk($sformatf("%s_v_s%0d", tag, t), 64'(valid4), 64'(e[35:32]));
        chk($sformatf("%s_busy_s%0d", tag, t), 64'(busy4), 64'd1);
        chk($sformatf("%s_done_s%0d", tag, t), 64'(done4), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset  = 1'b1;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; start2 = 1'b0;
        wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0; start4 = 1'b0;
        repeat (2) tick();

        // Reset values
        chk("rst_a2",    64'(a_out2), 64'd0);
        chk("rst_v2",    64'(valid2), 64'd0);
        chk("rst_busy2", 64'(busy2),  64'd0);
        chk("rst_done2", 64'(done2),  64'd0);
        chk("rst_a4",    64'(a_out4), 64'd0);
        chk("rst_v4",    64'(valid4), 64'd0);
        reset = 1'b0;
        tick();

        // Basic skew: A = [1,2; 3,4]
        wr2(2'd0, 8'd1);
        wr2(2'd1, 8'd2);
        wr2(2'd2, 8'd3);
        wr2(2'd3, 8'd4);
        feed2("basic", {16'h0400, 16'h0302, 16'h0001}, 1'b0, 1'b0);

        // Write + start during the feed are ignored
        feed2("midfeed", {16'h0400, 16'h0302, 16'h0001}, 1'b1, 1'b0);
        feed2("after_mid", {16'h0400, 16'h0302, 16'h0001}, 1'b0, 1'b0);

        // Write coinciding with an accepted start is discarded
        feed2("collide", {16'h0400, 16'h0302, 16'h0001}, 1'b0, 1'b1);
        feed2("after_col", {16'h0400, 16'h0302, 16'h0001}, 1'b0, 1'b0);

        // Reset during step 1
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("rstmid_s0_a", 64'(a_out2), 64'h0001);
        tick();
        chk("rstmid_s1_a", 64'(a_out2), 64'h0302);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_async_a",    64'(a_out2), 64'd0);
        chk("rstmid_async_v",    64'(valid2), 64'd0);
        chk("rstmid_async_busy", 64'(busy2),  64'd0);
        chk("rstmid_async_done", 64'(done2),  64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rstmid_nodone_%0d", i), 64'(done2), 64'd0);
            chk($sformatf("rstmid_idle_%0d", i), 64'(busy2), 64'd0);
        end

        // Buffer was cleared: zero data, normal valid pattern
        feed2("post_rst", 48'd0, 1'b0, 1'b0);

        // Zero operands: A = [0,5; 0,0]
        wr2(2'd0, 8'd0);
        wr2(2'd1, 8'd5);
        wr2(2'd2, 8'd0);
        wr2(2'd3, 8'd0);
        feed2("zero", {16'h0000, 16'h0005, 16'h0000}, 1'b0, 1'b0);

        // N=4: load 1..16, two back-to-back feeds
        for (int i = 0; i < 16; i++) begin
            wr4(4'(i), 8'(i + 1));
        end
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk4_step("n4_f1", 0);
        for (int t = 1; t < 7; t++) begin
            tick();
            chk4_step("n4_f1", t);
            if (t == 3) begin
                chk("n4_row3_first", 64'(a_out4[31:24]), 64'd13);
                chk("n4_row3_valid", 64'(valid4), 64'hf);
            end
        end
        tick();
        chk("n4_f1_done",      64'(done4),  64'd1);
        chk("n4_f1_done_busy", 64'(busy4),  64'd0);
        chk("n4_f1_done_a",    64'(a_out4), 64'd0);
        chk("n4_f1_done_v",    64'(valid4), 64'd0);
        // Start again in the done cycle
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("n4_f2_first_a0", 64'(a_out4[7:0]), 64'd1);
        chk4_step("n4_f2", 0);
        for (int t = 1; t < 7; t++) begin
            tick();
            chk4_step("n4_f2", t);
        end
        tick();
        chk("n4_f2_done",      64'(done4), 64'd1);
        chk("n4_f2_done_busy", 64'(busy4), 64'd0);
        tick();
        chk("n4_f2_post_done", 64'(done4), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
